mole_game_ctrl: RTL and testbench

Game-logic stage directly upstream of vga_display in the whack-a-mole design.
- Picks pseudo-random mole positions and judges player guesses against them.
- Keeps a two-digit BCD score and runs the round timer.
- Drives exactly the signals vga_display consumes: mole_position, guess_correct, guess_wrong, game_over, digit_1, digit_2.

---
 rtl/mole_game_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_mole_game_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game logic: picks mole holes from an LFSR, judges guesses, keeps a
// saturating two-digit BCD score and runs the round timer feeding vga_display.
module mole_game_ctrl #(
  parameter int unsigned TICK_DIV       = 25000000,
  parameter int unsigned MOLE_TICKS     = 2,
  parameter int unsigned FEEDBACK_TICKS = 1,
  parameter int unsigned GAME_TICKS     = 60,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       guess_valid,
  input  logic [2:0] guess_pos,
  output logic [2:0] mole_position,
  output logic       guess_correct,
  output logic       guess_wrong,
  output logic       game_over,
  output logic [3:0] digit_1,
  output logic [3:0] digit_2
);

  localparam int unsigned DivW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned MoleW = $clog2(MOLE_TICKS + 1);
  localparam int unsigned FbW   = $clog2(FEEDBACK_TICKS + 1);
  localparam int unsigned GameW = $clog2(GAME_TICKS + 1);

  localparam logic [DivW-1:0]  DivLast   = DivW'(TICK_DIV - 1);
  localparam logic [MoleW-1:0] MoleLoad  = MoleW'(MOLE_TICKS);
  localparam logic [FbW-1:0]   FbLoad    = FbW'(FEEDBACK_TICKS);
  localparam logic [GameW-1:0] GameLoad  = GameW'(GAME_TICKS);
  localparam logic [MoleW-1:0] MoleOne   = MoleW'(1);
  localparam logic [FbW-1:0]   FbOne     = FbW'(1);
  localparam logic [GameW-1:0] GameOne   = GameW'(1);

  typedef enum logic [1:0] {StIdle, StShow, StFb, StOver} state_e;

  state_e           state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [MoleW-1:0] mole_cnt_q, mole_cnt_d;
  logic [FbW-1:0]   fb_cnt_q, fb_cnt_d;
  logic [GameW-1:0] game_cnt_q, game_cnt_d;
  logic [2:0]       mole_q, mole_d;
  logic             correct_q, correct_d;
  logic             wrong_q, wrong_d;
  logic             over_q, over_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;

  logic       tick;
  logic       game_expire;
  logic [2:0] new_mole;
  logic [3:0] tens_inc, ones_inc;

  assign tick        = (div_q == DivLast);
  assign div_d       = tick ? '0 : div_q + DivW'(1);
  assign lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign game_expire = tick && (game_cnt_q <= GameOne);
  // Bump a repeated candidate by one so consecutive moles never share a hole.
  assign new_mole    = (lfsr_q[2:0] == mole_q) ? mole_q + 3'd1 : lfsr_q[2:0];

  always_comb begin
    tens_inc = tens_q;
    ones_inc = ones_q;
    if (!(tens_q == 4'd9 && ones_q == 4'd9)) begin
      if (ones_q == 4'd9) begin
        ones_inc = 4'd0;
        tens_inc = tens_q + 4'd1;
      end else begin
        ones_inc = ones_q + 4'd1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    mole_cnt_d = mole_cnt_q;
    fb_cnt_d   = fb_cnt_q;
    game_cnt_d = game_cnt_q;
    mole_d     = mole_q;
    correct_d  = correct_q;
    wrong_d    = wrong_q;
    over_d     = over_q;
    tens_d     = tens_q;
    ones_d     = ones_q;

    unique case (state_q)
      StIdle, StOver: begin
        if (start) begin
          state_d    = StShow;
          tens_d     = 4'd0;
          ones_d     = 4'd0;
          game_cnt_d = GameLoad;
          mole_d     = new_mole;
          mole_cnt_d = MoleLoad;
          correct_d  = 1'b0;
          wrong_d    = 1'b0;
          over_d     = 1'b0;
        end
      end

      StShow: begin
        if (game_expire) begin
          state_d    = StOver;
          game_cnt_d = '0;
          over_d     = 1'b1;
          correct_d  = 1'b0;
          wrong_d    = 1'b0;
        end else begin
          if (tick) begin
            game_cnt_d = game_cnt_q - GameOne;
            mole_cnt_d = mole_cnt_q - MoleOne;
          end
          if (guess_valid) begin
            state_d  = StFb;
            fb_cnt_d = FbLoad;
            if (guess_pos == mole_q) begin
              correct_d = 1'b1;
              tens_d    = tens_inc;
              ones_d    = ones_inc;
            end else begin
              wrong_d = 1'b1;
            end
          end else if (tick && (mole_cnt_q <= MoleOne)) begin
            state_d  = StFb;
            fb_cnt_d = FbLoad;
            wrong_d  = 1'b1;
          end
        end
      end

      StFb: begin
        if (game_expire) begin
          state_d    = StOver;
          game_cnt_d = '0;
          over_d     = 1'b1;
          correct_d  = 1'b0;
          wrong_d    = 1'b0;
        end else if (tick) begin
          game_cnt_d = game_cnt_q - GameOne;
          fb_cnt_d   = fb_cnt_q - FbOne;
          if (fb_cnt_q <= FbOne) begin
            state_d    = StShow;
            correct_d  = 1'b0;
            wrong_d    = 1'b0;
            mole_d     = new_mole;
            mole_cnt_d = MoleLoad;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      div_q      <= '0;
      lfsr_q     <= LFSR_SEED;
      mole_cnt_q <= '0;
      fb_cnt_q   <= '0;
      game_cnt_q <= '0;
      mole_q     <= 3'd0;
      correct_q  <= 1'b0;
      wrong_q    <= 1'b0;
      over_q     <= 1'b0;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      lfsr_q     <= lfsr_d;
      mole_cnt_q <= mole_cnt_d;
      fb_cnt_q   <= fb_cnt_d;
      game_cnt_q <= game_cnt_d;
      mole_q     <= mole_d;
      correct_q  <= correct_d;
      wrong_q    <= wrong_d;
      over_q     <= over_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
    end
  end

  assign mole_position = mole_q;
  assign guess_correct = correct_q;
  assign guess_wrong   = wrong_q;
  assign game_over     = over_q;
  assign digit_1       = tens_q;
  assign digit_2       = ones_q;

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Directed bench for mole_game_ctrl; a second instance with a long round covers
// the BCD carry and the 99 saturation, which a 20-tick round cannot reach.
module tb_mole_game_ctrl;

  localparam int unsigned TD = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, guess_valid = 1'b0;
  logic [2:0] guess_pos = 3'd0;
  logic [2:0] mole_position;
  logic       guess_correct, guess_wrong, game_over;
  logic [3:0] digit_1, digit_2;

  logic       start_b = 1'b0, guess_valid_b = 1'b0;
  logic [2:0] guess_pos_b = 3'd0;
  logic [2:0] mole_position_b;
  logic       guess_correct_b, guess_wrong_b, game_over_b;
  logic [3:0] digit_1_b, digit_2_b;

  mole_game_ctrl #(
    .TICK_DIV(TD), .MOLE_TICKS(3), .FEEDBACK_TICKS(2), .GAME_TICKS(20), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .guess_valid(guess_valid), .guess_pos(guess_pos),
    .mole_position(mole_position), .guess_correct(guess_correct), .guess_wrong(guess_wrong),
    .game_over(game_over), .digit_1(digit_1), .digit_2(digit_2)
  );

  mole_game_ctrl #(
    .TICK_DIV(2), .MOLE_TICKS(3), .FEEDBACK_TICKS(1), .GAME_TICKS(250), .LFSR_SEED(SEED)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .guess_valid(guess_valid_b),
    .guess_pos(guess_pos_b), .mole_position(mole_position_b),
    .guess_correct(guess_correct_b), .guess_wrong(guess_wrong_b), .game_over(game_over_b),
    .digit_1(digit_1_b), .digit_2(digit_2_b)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] m_lfsr, prev_lfsr;
  int unsigned m_div;
  bit          prev_tick;
  int          tick_count = 0;
  int          ts;
  int          score;
  logic [2:0]  exp_mole, old_mole;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [2:0] pick(input logic [15:0] s, input logic [2:0] cur);
    logic [2:0] c;
    c = s[2:0];
    return (c == cur) ? c + 3'd1 : c;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; the divider/LFSR model advances with the DUT and pre-edge values are kept.
  task automatic step();
    prev_lfsr = m_lfsr;
    prev_tick = (m_div == TD - 1);
    @(posedge clk);
    m_lfsr = lfsr_step(m_lfsr);
    m_div  = prev_tick ? 0 : m_div + 1;
    if (prev_tick) tick_count++;
    #1;
    check("flags_exclusive", 16'(guess_correct & guess_wrong), 16'd0);
    check("flags_exclusive_b", 16'(guess_correct_b & guess_wrong_b), 16'd0);
    check("ones_bcd", 16'(digit_2 <= 4'd9), 16'd1);
    check("tens_bcd_b", 16'(digit_1_b <= 4'd9), 16'd1);
  endtask

  task automatic wait_ticks(input int n);
    int target;
    target = tick_count + n;
    for (int i = 0; i < n * TD * 2 + 4 && tick_count < target; i++) step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mole"}, 16'(mole_position), 16'd0);
    check({tag, "_correct"}, 16'(guess_correct), 16'd0);
    check({tag, "_wrong"}, 16'(guess_wrong), 16'd0);
    check({tag, "_over"}, 16'(game_over), 16'd0);
    check({tag, "_d1"}, 16'(digit_1), 16'd0);
    check({tag, "_d2"}, 16'(digit_2), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_lfsr = SEED;
    m_div  = 0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("in_reset");
    rst = 1'b0;

    // 1: idle after reset
    repeat (50) step();
    check_all_zero("idle50");
    check("idle50_over_b", 16'(game_over_b), 16'd0);

    // 2: correct hit
    start = 1'b1; step(); start = 1'b0;
    exp_mole = pick(prev_lfsr, 3'd0);
    check("start_mole", 16'(mole_position), 16'(exp_mole));
    guess_valid = 1'b1; guess_pos = exp_mole; step(); guess_valid = 1'b0;
    check("hit_correct", 16'(guess_correct), 16'd1);
    check("hit_wrong", 16'(guess_wrong), 16'd0);
    check("hit_d1", 16'(digit_1), 16'd0);
    check("hit_d2", 16'(digit_2), 16'd1);
    old_mole = exp_mole;
    wait_ticks(1);
    check("fb_hold_correct", 16'(guess_correct), 16'd1);
    check("fb_hold_mole", 16'(mole_position), 16'(old_mole));
    wait_ticks(1);
    exp_mole = pick(prev_lfsr, old_mole);
    check("fb_end_correct", 16'(guess_correct), 16'd0);
    check("next_mole", 16'(mole_position), 16'(exp_mole));
    check("next_mole_differs", 16'(mole_position != old_mole), 16'd1);

    // 3: wrong hit, then a guess during feedback is ignored
    guess_valid = 1'b1; guess_pos = exp_mole + 3'd1; step(); guess_valid = 1'b0;
    check("miss_wrong", 16'(guess_wrong), 16'd1);
    check("miss_correct", 16'(guess_correct), 16'd0);
    check("miss_d1", 16'(digit_1), 16'd0);
    check("miss_d2", 16'(digit_2), 16'd1);
    guess_valid = 1'b1; guess_pos = exp_mole; step(); guess_valid = 1'b0;
    check("fb_guess_d2", 16'(digit_2), 16'd1);
    check("fb_guess_correct", 16'(guess_correct), 16'd0);
    check("fb_guess_wrong", 16'(guess_wrong), 16'd1);
    for (int i = 0; i < 40 && guess_wrong; i++) step();
    check("miss_fb_end", 16'(guess_wrong), 16'd0);
    check("miss_fb_end_d2", 16'(digit_2), 16'd1);

    // 1b: asynchronous reset mid-round
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    #1;
    rst = 1'b0;
    m_lfsr = SEED;
    m_div  = 0;

    // 4: no guesses, mole timeouts until the round ends
    start = 1'b1; step(); start = 1'b0;
    ts = tick_count;
    exp_mole = pick(prev_lfsr, 3'd0);
    check("r4_mole", 16'(mole_position), 16'(exp_mole));
    wait_ticks(2);
    check("r4_t2_wrong", 16'(guess_wrong), 16'd0);
    wait_ticks(1);
    check("r4_t3_wrong", 16'(guess_wrong), 16'd1);
    check("r4_t3_correct", 16'(guess_correct), 16'd0);
    wait_ticks(2);
    old_mole = exp_mole;
    exp_mole = pick(prev_lfsr, old_mole);
    check("r4_t5_wrong", 16'(guess_wrong), 16'd0);
    check("r4_t5_mole", 16'(mole_position), 16'(exp_mole));
    wait_ticks(3);
    check("r4_t8_wrong", 16'(guess_wrong), 16'd1);
    wait_ticks(11);
    check("r4_t19_over", 16'(game_over), 16'd0);
    wait_ticks(1);
    check("r4_t20_over", 16'(game_over), 16'd1);
    check("r4_t20_wrong", 16'(guess_wrong), 16'd0);
    check("r4_t20_d1", 16'(digit_1), 16'd0);
    check("r4_t20_d2", 16'(digit_2), 16'd0);
    repeat (12) step();
    check("r4_over_hold", 16'(game_over), 16'd1);

    // 5: BCD carry and saturation on the long-round instance
    start_b = 1'b1; step(); start_b = 1'b0;
    score = 0;
    for (int i = 1; i <= 100; i++) begin
      guess_valid_b = 1'b1; guess_pos_b = mole_position_b; step(); guess_valid_b = 1'b0;
      if (score < 99) score++;
      check("sat_correct", 16'(guess_correct_b), 16'd1);
      check("sat_d1", 16'(digit_1_b), 16'(score / 10));
      check("sat_d2", 16'(digit_2_b), 16'(score % 10));
      for (int k = 0; k < 20 && guess_correct_b; k++) step();
      check("sat_fb_end", 16'(guess_correct_b), 16'd0);
    end
    check("sat_not_over", 16'(game_over_b), 16'd0);

    // 6: restart from OVER, then a correct guess on the expiry edge
    start = 1'b1; step(); start = 1'b0;
    ts = tick_count;
    check("r6_over_clear", 16'(game_over), 16'd0);
    check("r6_d1", 16'(digit_1), 16'd0);
    check("r6_d2", 16'(digit_2), 16'd0);
    guess_valid = 1'b1; guess_pos = mole_position; step(); guess_valid = 1'b0;
    check("r6_hit", 16'(guess_correct), 16'd1);
    check("r6_hit_d2", 16'(digit_2), 16'd1);
    for (int i = 0; i < 200 && (tick_count - ts) < 19; i++) step();
    for (int i = 0; i < 2 * TD && m_div != TD - 1; i++) step();
    guess_valid = 1'b1; guess_pos = mole_position; step(); guess_valid = 1'b0;
    check("exp_over", 16'(game_over), 16'd1);
    check("exp_correct", 16'(guess_correct), 16'd0);
    check("exp_wrong", 16'(guess_wrong), 16'd0);
    check("exp_d1", 16'(digit_1), 16'd0);
    check("exp_d2", 16'(digit_2), 16'd1);
    repeat (10) step();
    check("over_hold_over", 16'(game_over), 16'd1);
    check("over_hold_d2", 16'(digit_2), 16'd1);
    start = 1'b1; step(); start = 1'b0;
    check("restart_over", 16'(game_over), 16'd0);
    check("restart_d1", 16'(digit_1), 16'd0);
    check("restart_d2", 16'(digit_2), 16'd0);
    check("restart_correct", 16'(guess_correct), 16'd0);
    check("restart_wrong", 16'(guess_wrong), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
